// File: rtl/mb_mult_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mb_mult_pkg : shared widths, mode encoding and helpers for the mb mult    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package mb_mult_pkg;

   localparam int WIDTH   = 8;
   localparam int SHIFT_W = $clog2(WIDTH);
   localparam int CHAR_W  = SHIFT_W + 1;

   // Same encoding drives the barrel shifter direction input.
   localparam logic MODE_NORM    = 1'b0;
   localparam logic MODE_EXTRACT = 1'b1;

   localparam logic [SHIFT_W-1:0] K_MAX = SHIFT_W'(WIDTH - 1);

   typedef struct packed {
      logic [WIDTH-1:0]   data_a;
      logic [WIDTH-1:0]   data_b;
      logic               mode;
      logic [SHIFT_W-1:0] k_a;
      logic [SHIFT_W-1:0] k_b;
      logic               zero_a;
      logic               zero_b;
   } stage1_t;

   typedef struct packed {
      logic [WIDTH-1:0]   data_a;
      logic [WIDTH-1:0]   data_b;
      logic [SHIFT_W-1:0] shift_a;
      logic [SHIFT_W-1:0] shift_b;
      logic               dir;
      logic [CHAR_W-1:0]  char_sum;
      logic               zero;
   } stage2_t;

   function automatic logic [SHIFT_W-1:0] shift_amount(
      input logic [SHIFT_W-1:0] k,
      input logic               zero,
      input logic               mode
   );
      logic [SHIFT_W-1:0] amt;
      if (zero) begin
         amt = '0;
      end else if (mode == MODE_EXTRACT) begin
         amt = k;
      end else begin
         amt = K_MAX - k;
      end
      return amt;
   endfunction

   function automatic logic [CHAR_W-1:0] char_sum(
      input logic [SHIFT_W-1:0] k_a,
      input logic [SHIFT_W-1:0] k_b,
      input logic               zero
   );
      logic [CHAR_W-1:0] sum;
      sum = zero ? '0 : (CHAR_W'(k_a) + CHAR_W'(k_b));
      return sum;
   endfunction

endpackage
`default_nettype wire

// File: rtl/lead_one_detector.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lead_one_detector : index of the most-significant set bit, plus zero flag |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module lead_one_detector
   import mb_mult_pkg::*;
(
   input  logic [WIDTH-1:0]   i_operand,
   output logic [SHIFT_W-1:0] o_lead_idx,
   output logic               o_is_zero
);

   // Ascending scan so the highest set bit wins; zero operand reports index 0.
   always_comb begin
      o_lead_idx = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (i_operand[i]) begin
            o_lead_idx = SHIFT_W'(i);
         end
      end
   end

   assign o_is_zero = (i_operand == '0);

endmodule
`default_nettype wire

// File: rtl/mb_operand_prep.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mb_operand_prep : 2-stage operand prep (lead-one, shift ctl, char sum)    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module mb_operand_prep
   import mb_mult_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   input  logic               in_mode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data_a,
   output logic [WIDTH-1:0]   out_data_b,
   output logic [SHIFT_W-1:0] out_shift_a,
   output logic [SHIFT_W-1:0] out_shift_b,
   output logic               out_dir,
   output logic [CHAR_W-1:0]  out_char_sum,
   output logic               out_zero
);

   logic               w_en;
   logic [SHIFT_W-1:0] w_k_a;
   logic [SHIFT_W-1:0] w_k_b;
   logic               w_zero_a;
   logic               w_zero_b;

   stage1_t            s1_d;
   stage1_t            s1_q;
   logic               s1_valid_d;
   logic               s1_valid_q;
   stage2_t            s2_d;
   stage2_t            s2_q;
   logic               s2_valid_d;
   logic               s2_valid_q;

   lead_one_detector u_lod_a (
      .i_operand  (in_a),
      .o_lead_idx (w_k_a),
      .o_is_zero  (w_zero_a)
   );

   lead_one_detector u_lod_b (
      .i_operand  (in_b),
      .o_lead_idx (w_k_b),
      .o_is_zero  (w_zero_b)
   );

   // Whole pipe advances together; a held output freezes both stages.
   assign w_en     = !s2_valid_q || out_ready;
   assign in_ready = w_en;

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_d       = s1_q;
      s2_valid_d = s2_valid_q;
      s2_d       = s2_q;
      if (w_en) begin
         s1_valid_d      = in_valid;
         s1_d.data_a     = in_a;
         s1_d.data_b     = in_b;
         s1_d.mode       = in_mode;
         s1_d.k_a        = w_k_a;
         s1_d.k_b        = w_k_b;
         s1_d.zero_a     = w_zero_a;
         s1_d.zero_b     = w_zero_b;

         s2_valid_d      = s1_valid_q;
         s2_d.data_a     = s1_q.data_a;
         s2_d.data_b     = s1_q.data_b;
         s2_d.shift_a    = shift_amount(s1_q.k_a, s1_q.zero_a, s1_q.mode);
         s2_d.shift_b    = shift_amount(s1_q.k_b, s1_q.zero_b, s1_q.mode);
         s2_d.dir        = s1_q.mode;
         s2_d.zero       = s1_q.zero_a || s1_q.zero_b;
         s2_d.char_sum   = char_sum(s1_q.k_a, s1_q.k_b, s1_q.zero_a || s1_q.zero_b);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_q       <= '0;
         s2_valid_q <= 1'b0;
         s2_q       <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_q       <= s1_d;
         s2_valid_q <= s2_valid_d;
         s2_q       <= s2_d;
      end
   end

   assign out_valid    = s2_valid_q;
   assign out_data_a   = s2_q.data_a;
   assign out_data_b   = s2_q.data_b;
   assign out_shift_a  = s2_q.shift_a;
   assign out_shift_b  = s2_q.shift_b;
   assign out_dir      = s2_q.dir;
   assign out_char_sum = s2_q.char_sum;
   assign out_zero     = s2_q.zero;

endmodule
`default_nettype wire

// File: tb/tb_mb_operand_prep.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mb_operand_prep : directed + random checks against a reference model   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_mb_operand_prep;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_a;
   logic [7:0] in_b;
   logic       in_mode;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data_a;
   logic [7:0] out_data_b;
   logic [2:0] out_shift_a;
   logic [2:0] out_shift_b;
   logic       out_dir;
   logic [3:0] out_char_sum;
   logic       out_zero;

   always #5 clk = ~clk;

   mb_operand_prep dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_a         (in_a),
      .in_b         (in_b),
      .in_mode      (in_mode),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data_a   (out_data_a),
      .out_data_b   (out_data_b),
      .out_shift_a  (out_shift_a),
      .out_shift_b  (out_shift_b),
      .out_dir      (out_dir),
      .out_char_sum (out_char_sum),
      .out_zero     (out_zero)
   );

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [2:0] sa;
      logic [2:0] sb;
      logic       dir;
      logic [3:0] sum;
      logic       zero;
   } exp_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad   = 0;
   int   n_emit = 0;
   logic last_acc = 1'b0;

   function automatic int lead_k(input int x);
      return (x == 0) ? 0 : $clog2(x + 1) - 1;
   endfunction

   function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic m);
      exp_t e;
      int   ka;
      int   kb;
      ka     = lead_k(int'(a));
      kb     = lead_k(int'(b));
      e.a    = a;
      e.b    = b;
      e.dir  = m;
      e.zero = (a == 8'd0) || (b == 8'd0);
      e.sa   = (a == 8'd0) ? 3'd0 : (m ? 3'(ka) : 3'(7 - ka));
      e.sb   = (b == 8'd0) ? 3'd0 : (m ? 3'(kb) : 3'(7 - kb));
      e.sum  = e.zero ? 4'd0 : 4'(ka + kb);
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                        input logic m, input logic r);
      in_valid  = v;
      in_a      = a;
      in_b      = b;
      in_mode   = m;
      out_ready = r;
   endtask

   // One clock: check/pop the output and record acceptance just before the edge.
   task automatic step();
      exp_t e;
      @(negedge clk);
      last_acc = 1'b0;
      if (!rst_n) begin
         sb_q.delete();
      end else begin
         if (out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
               chk("spurious_out_valid", 32'(out_valid), 32'd0);
            end else begin
               e = sb_q[0];
               chk("data_a",   32'(out_data_a),   32'(e.a));
               chk("data_b",   32'(out_data_b),   32'(e.b));
               chk("shift_a",  32'(out_shift_a),  32'(e.sa));
               chk("shift_b",  32'(out_shift_b),  32'(e.sb));
               chk("dir",      32'(out_dir),      32'(e.dir));
               chk("char_sum", 32'(out_char_sum), 32'(e.sum));
               chk("zero",     32'(out_zero),     32'(e.zero));
               if (out_ready) begin
                  void'(sb_q.pop_front());
                  n_emit++;
               end
            end
         end
         if (in_valid && in_ready) begin
            sb_q.push_back(model(in_a, in_b, in_mode));
            last_acc = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] pa[4];
      logic [7:0] pb[4];
      logic       cur_v;
      logic [7:0] cur_a;
      logic [7:0] cur_b;
      logic       cur_m;
      int         idx;
      int         acc;
      int         cyc;
      int         emit0;

      rst_n = 1'b0;
      drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      step();
      step();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      chk("rst_shift_a",   32'(out_shift_a), 32'd0);
      chk("rst_char_sum",  32'(out_char_sum), 32'd0);
      chk("rst_zero",      32'(out_zero), 32'd0);
      chk("rst_data_a",    32'(out_data_a), 32'd0);
      rst_n = 1'b1;

      // Leading one at opposite ends, normalize mode.
      drive(1'b1, 8'h01, 8'h80, 1'b0, 1'b1);
      step();
      drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      step();
      chk("t1_valid",    32'(out_valid),    32'd1);
      chk("t1_shift_a",  32'(out_shift_a),  32'd7);
      chk("t1_shift_b",  32'(out_shift_b),  32'd0);
      chk("t1_dir",      32'(out_dir),      32'd0);
      chk("t1_char_sum", 32'(out_char_sum), 32'd7);
      chk("t1_zero",     32'(out_zero),     32'd0);

      drive(1'b1, 8'h2C, 8'h13, 1'b1, 1'b1);
      step();
      drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      step();
      chk("t2_shift_a",  32'(out_shift_a),  32'd5);
      chk("t2_shift_b",  32'(out_shift_b),  32'd4);
      chk("t2_dir",      32'(out_dir),      32'd1);
      chk("t2_char_sum", 32'(out_char_sum), 32'd9);
      chk("t2_data_a",   32'(out_data_a),   32'h2C);
      chk("t2_data_b",   32'(out_data_b),   32'h13);

      drive(1'b1, 8'h00, 8'hFF, 1'b0, 1'b1);
      step();
      drive(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1);
      step();
      chk("t3_zero",     32'(out_zero),     32'd1);
      chk("t3_shift_a",  32'(out_shift_a),  32'd0);
      chk("t3_char_sum", 32'(out_char_sum), 32'd0);
      drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      step();
      chk("t3_max_sum",  32'(out_char_sum), 32'd14);
      chk("t3_max_zero", 32'(out_zero),     32'd0);
      step();
      step();

      // Back-to-back stream with a 3-cycle downstream stall.
      pa = '{8'h03, 8'h40, 8'h11, 8'hA5};
      pb = '{8'h7F, 8'h02, 8'h00, 8'h09};
      emit0 = n_emit;
      idx = 0;
      for (int c = 0; c < 20 && idx < 4; c++) begin
         drive(1'b1, pa[idx], pb[idx], c[0], !(c >= 2 && c < 5));
         step();
         if (last_acc) idx++;
         if (c >= 2 && c < 5) begin
            chk("t4_stall_in_ready", 32'(in_ready),  32'd0);
            chk("t4_stall_valid",    32'(out_valid), 32'd1);
         end
      end
      chk("t4_all_accepted", 32'(idx), 32'd4);
      drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      for (int c = 0; c < 5; c++) step();
      chk("t4_emitted", 32'(n_emit - emit0), 32'd4);
      chk("t4_drained", 32'(sb_q.size()),    32'd0);

      // Reset with two pairs in flight.
      drive(1'b1, 8'h55, 8'h66, 1'b0, 1'b0);
      step();
      drive(1'b1, 8'h77, 8'h88, 1'b1, 1'b0);
      step();
      drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("t5_valid_after_rst", 32'(out_valid), 32'd0);
      emit0 = n_emit;
      for (int c = 0; c < 5; c++) step();
      chk("t5_nothing_emerged", 32'(n_emit - emit0), 32'd0);

      // Random traffic with valid/ready toggling.
      emit0 = n_emit;
      acc   = 0;
      cyc   = 0;
      cur_v = 1'b0;
      cur_a = 8'h00;
      cur_b = 8'h00;
      cur_m = 1'b0;
      while (acc < 1000 && cyc < 20000) begin
         if (!cur_v || last_acc) begin
            cur_v = ($urandom_range(0, 3) != 0);
            cur_a = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            cur_b = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            cur_m = 1'($urandom);
         end
         drive(cur_v, cur_a, cur_b, cur_m, $urandom_range(0, 3) != 0);
         step();
         if (last_acc) acc++;
         cyc++;
      end
      chk("t6_accepted", 32'(acc), 32'd1000);
      drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      for (int c = 0; c < 10; c++) step();
      chk("t6_emitted", 32'(n_emit - emit0), 32'd1000);
      chk("t6_drained", 32'(sb_q.size()),    32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
